// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and helpers for the stream_mux_arb stream multiplexer.
package stream_mux_arb_pkg;

    localparam int MUX_MODE_RR   = 0;
    localparam int MUX_MODE_PRIO = 1;
    localparam int MUX_MODE_SEL  = 2;

    // Increment modulo n; works for any n, not only powers of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first request at or after ptr wins.
module rr_arbiter
    import stream_mux_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    always_comb begin
        idx        = 0;
        any        = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-input registered stream multiplexer with round-robin, fixed-priority or explicit select.
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = 0,
    localparam int SW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_chan,
    input  logic            out_ready
);

    localparam bit USE_PTR = (MODE != MUX_MODE_PRIO) && (MODE != MUX_MODE_SEL);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SW-1:0]   out_chan_q, out_chan_d;
    logic [SW-1:0]   ptr_q, ptr_d;

    logic [N-1:0]    cand;
    logic [N-1:0]    gnt_onehot;
    logic [SW-1:0]   gnt_idx;
    logic [SW-1:0]   arb_ptr;
    logic            gnt_any;
    logic            load;
    logic            xfer;

    // Select mode offers at most one candidate, so the arbiter just echoes sel.
    always_comb begin
        cand = '0;
        if (MODE == MUX_MODE_SEL) begin
            if (int'(sel) < N) begin
                cand[sel] = in_valid[sel];
            end
        end else begin
            cand = in_valid;
        end
    end

    assign arb_ptr = USE_PTR ? ptr_q : '0;

    rr_arbiter #(.N(N)) u_arb (
        .req        (cand),
        .ptr        (arb_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign load     = !out_valid_q || out_ready;
    assign in_ready = (reset_n && load && gnt_any) ? gnt_onehot : '0;
    assign xfer     = |(in_ready & in_valid);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(gnt_idx)*W +: W];
            out_chan_d  = gnt_idx;
            if (USE_PTR) begin
                ptr_d = SW'(wrap_inc(int'(gnt_idx), N));
            end
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: round-robin, priority and select instances plus an N=3 select instance.
module tb_stream_mux_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0]  rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [7:0]  od0, od1, od2;
    logic [1:0]  oc0, oc1, oc2;

    logic [2:0]  v3;
    logic [23:0] d3;
    logic [1:0]  sel3;
    logic        ord3;
    logic [2:0]  rdy3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;

    int n_pass  = 0;
    int n_total = 0;
    int exp_rr[3] = '{3, 1, 3};

    always #5 clk = ~clk;

    stream_mux_arb #(.N(4), .W(8), .MODE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .sel(sel), .out_valid(ov0), .out_data(od0), .out_chan(oc0), .out_ready(out_ready));
    stream_mux_arb #(.N(4), .W(8), .MODE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .sel(sel), .out_valid(ov1), .out_data(od1), .out_chan(oc1), .out_ready(out_ready));
    stream_mux_arb #(.N(4), .W(8), .MODE(2)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
        .sel(sel), .out_valid(ov2), .out_data(od2), .out_chan(oc2), .out_ready(out_ready));
    stream_mux_arb #(.N(3), .W(8), .MODE(2)) u3 (
        .clk(clk), .reset_n(reset_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .sel(sel3), .out_valid(ov3), .out_data(od3), .out_chan(oc3), .out_ready(ord3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        sel       = 2'd2;
        out_ready = 1'b1;
        v3        = 3'b111;
        d3        = {8'hC2, 8'hC1, 8'hC0};
        sel3      = 2'd2;
        ord3      = 1'b1;

        // reset held with all inputs valid
        repeat (3) begin
            step();
            chk("rst_ready0", 32'(rdy0), 32'h0);
        end
        chk("rst_valid", 32'(ov0), 32'h0);
        chk("rst_data", 32'(od0), 32'h0);
        chk("rst_chan", 32'(oc0), 32'h0);
        chk("rst_ready1", 32'(rdy1), 32'h0);

        // round-robin streaming
        reset_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(rdy0), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("rr_ready", 32'(rdy0), 32'(4'b0001 << (i % 4)));
            step();
            chk("rr_valid", 32'(ov0), 32'h1);
            chk("rr_chan", 32'(oc0), 32'(i % 4));
            chk("rr_data", 32'(od0), 32'(8'hA0 + 8'(i % 4)));
        end

        // backpressure after word A0
        step();
        chk("bp_first_data", 32'(od0), 32'hA0);
        out_ready = 1'b0;
        #1;
        chk("bp_ready_now", 32'(rdy0), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ready", 32'(rdy0), 32'h0);
            chk("bp_valid", 32'(ov0), 32'h1);
            chk("bp_data", 32'(od0), 32'hA0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rdy0), 32'h2);
        step();
        chk("bp_release_chan", 32'(oc0), 32'h1);
        chk("bp_release_data", 32'(od0), 32'hA1);

        // fixed priority; round-robin skips the idle channels meanwhile
        in_valid = 4'b1010;
        #1;
        chk("prio_ready", 32'(rdy1), 32'h2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("prio_chan", 32'(oc1), 32'h1);
            chk("prio_data", 32'(od1), 32'hA1);
            chk("rr_skip_chan", 32'(oc0), 32'(exp_rr[k]));
        end
        in_valid = 4'b1000;
        #1;
        chk("prio_drop_ready", 32'(rdy1), 32'h8);
        step();
        chk("prio_drop_chan", 32'(oc1), 32'h3);
        chk("prio_drop_data", 32'(od1), 32'hA3);
        chk("rr_wrap_chan", 32'(oc0), 32'h3);

        // explicit select
        in_valid = 4'b1111;
        sel = 2'd2;
        #1;
        chk("sel2_ready", 32'(rdy2), 32'h4);
        step();
        chk("sel2_chan", 32'(oc2), 32'h2);
        chk("sel2_data", 32'(od2), 32'hA2);
        chk("rr_after_wrap", 32'(oc0), 32'h0);
        sel = 2'd1;
        #1;
        chk("sel1_ready", 32'(rdy2), 32'h2);
        step();
        chk("sel1_chan", 32'(oc2), 32'h1);
        chk("sel1_data", 32'(od2), 32'hA1);
        in_valid = 4'b0000;

        // N=3 select with an out-of-range sel
        chk("n3_valid", 32'(ov3), 32'h1);
        chk("n3_chan", 32'(oc3), 32'h2);
        chk("n3_data", 32'(od3), 32'hC2);
        sel3 = 2'd3;
        #1;
        chk("n3_bad_sel_ready", 32'(rdy3), 32'h0);
        step();
        chk("n3_drain", 32'(ov3), 32'h0);
        step();
        chk("n3_idle", 32'(ov3), 32'h0);
        chk("n3_idle_ready", 32'(rdy3), 32'h0);
        sel3 = 2'd1;
        #1;
        chk("n3_sel1_ready", 32'(rdy3), 32'h2);
        step();
        chk("n3_sel1_chan", 32'(oc3), 32'h1);
        chk("n3_sel1_data", 32'(od3), 32'hC1);
        chk("rr_idle_valid", 32'(ov0), 32'h0);

        // mid-stream reset; rr pointer was left at 2
        in_valid = 4'b1111;
        #1;
        chk("mid_ready", 32'(rdy0), 32'h4);
        step();
        chk("mid_chan", 32'(oc0), 32'h2);
        chk("mid_valid", 32'(ov0), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready0", 32'(rdy0), 32'h0);
        chk("mid_rst_ready2", 32'(rdy2), 32'h0);
        step();
        chk("mid_rst_valid", 32'(ov0), 32'h0);
        chk("mid_rst_data", 32'(od0), 32'h0);
        chk("mid_rst_chan", 32'(oc0), 32'h0);
        reset_n = 1'b1;
        #1;
        chk("mid_restart_ready", 32'(rdy0), 32'h1);
        step();
        chk("mid_restart_chan", 32'(oc0), 32'h0);
        chk("mid_restart_data", 32'(od0), 32'hA0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
